// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rr_arb_state_t;

endpackage

// File: rtl/rr_arb_pri.sv
// Priority selector: returns a one-hot vector holding the winning request bit.
// FROM_LSB = 1 favours bit 0, FROM_LSB = 0 favours bit W-1.
module pri #(
    parameter int W        = 4,
    parameter bit FROM_LSB = 1'b1
) (
    input  logic [W-1:0] req_i,
    output logic [W-1:0] gnt_o
);

    if (FROM_LSB) begin : g_lsb
        // Two's-complement trick isolates the lowest set bit.
        assign gnt_o = req_i & (~req_i + W'(1));
    end else begin : g_msb
        // Scan upward so the highest set bit is the last one written.
        always_comb begin
            gnt_o = '0;
            for (int i = 0; i < W; i++) begin
                if (req_i[i]) gnt_o = W'(1) << i;
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with optional grant locking across multi-beat transactions.
//
// state  | meaning
// IDLE   | arbitrating every cycle; masked requests above the last winner win first
// LOCKED | grant held by owner_q until its last beat is accepted
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int W       = 4,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [W-1:0]         i_req,
    input  logic [W-1:0]         i_req_last,
    input  logic                 i_ack,
    output logic [W-1:0]         o_gnt,
    output logic                 o_gnt_vld,
    output logic [$clog2(W)-1:0] o_gnt_idx,
    output logic                 o_busy
);

    localparam int IW = $clog2(W);

    rr_arb_state_t state_q, state_d;
    logic [W-1:0]  ptr_mask_q, ptr_mask_d;
    logic [IW-1:0] owner_q, owner_d;

    logic [W-1:0]  req_masked;
    logic [W-1:0]  gnt_masked;
    logic [W-1:0]  gnt_unmasked;
    logic [W-1:0]  gnt_idle;
    logic [W-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          accept;
    logic          beat_last;

    // Priority mask that favours everything strictly above idx; wraps to all ones past the top.
    function automatic logic [W-1:0] mask_above(input logic [IW-1:0] idx);
        if (int'(idx) == W - 1) return '1;
        return {W{1'b1}} << (int'(idx) + 1);
    endfunction

    assign req_masked = i_req & ptr_mask_q;

    pri #(.W(W), .FROM_LSB(1'b1)) u_pri_masked (
        .req_i (req_masked),
        .gnt_o (gnt_masked)
    );

    pri #(.W(W), .FROM_LSB(1'b1)) u_pri_unmasked (
        .req_i (i_req),
        .gnt_o (gnt_unmasked)
    );

    assign gnt_idle = (|gnt_masked) ? gnt_masked : gnt_unmasked;

    // While locked only the owner can be granted; a dropped owner request leaves the grant empty.
    assign gnt = (state_q == LOCKED) ? ((W'(1) << owner_q) & i_req) : gnt_idle;

    // One-hot to binary by OR-reduction; relies on gnt being one-hot or zero.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (gnt[i]) gnt_idx = gnt_idx | IW'(i);
        end
    end

    assign accept    = i_ack & (|gnt);
    assign beat_last = |(gnt & i_req_last);

    // Next-state decode; only an accepted beat moves state, owner or pointer.
    always_comb begin
        state_d    = state_q;
        ptr_mask_d = ptr_mask_q;
        owner_d    = owner_q;
        if (accept) begin
            if (beat_last || !LOCK_EN) begin
                state_d    = IDLE;
                ptr_mask_d = mask_above(gnt_idx);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end
        end
    end

    // State registers; reset restarts arbitration from bit 0.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            ptr_mask_q <= '1;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_mask_q <= ptr_mask_d;
            owner_q    <= owner_d;
        end
    end

    assign o_gnt     = gnt;
    assign o_gnt_vld = |gnt;
    assign o_gnt_idx = gnt_idx;
    assign o_busy    = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_arb.sv
// Scoreboard bench for rr_arb: one locking instance and one non-locking instance share stimulus.
module tb_rr_arb;

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] i_req, i_req_last;
    logic       i_ack;

    logic [3:0] gnt_a, gnt_b;
    logic       vld_a, vld_b;
    logic [1:0] idx_a, idx_b;
    logic       busy_a, busy_b;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        logic       sel;
        logic [3:0] gnt;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arb #(.W(4), .LOCK_EN(1'b1)) dut (
        .clk        (clk),
        .arst       (arst),
        .i_req      (i_req),
        .i_req_last (i_req_last),
        .i_ack      (i_ack),
        .o_gnt      (gnt_a),
        .o_gnt_vld  (vld_a),
        .o_gnt_idx  (idx_a),
        .o_busy     (busy_a)
    );

    rr_arb #(.W(4), .LOCK_EN(1'b0)) dut_nl (
        .clk        (clk),
        .arst       (arst),
        .i_req      (i_req),
        .i_req_last (i_req_last),
        .i_ack      (i_ack),
        .o_gnt      (gnt_b),
        .o_gnt_vld  (vld_b),
        .o_gnt_idx  (idx_b),
        .o_busy     (busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        case (v)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input string tag, input logic sel, input logic [3:0] req,
                        input logic [3:0] last, input logic ack,
                        input logic [3:0] eg, input logic eb);
        exp_t e;
        i_req      = req;
        i_req_last = last;
        i_ack      = ack;
        e.sel  = sel;
        e.gnt  = eg;
        e.busy = eb;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        arst = 1'b1;
        #2;
        arst = 1'b0;
    endtask

    // Monitor: compare the selected instance against the oldest expectation each negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel == 1'b0) begin
                    chk({e.tag, "_gnt"},  gnt_a,  e.gnt);
                    chk({e.tag, "_vld"},  vld_a,  |e.gnt);
                    chk({e.tag, "_idx"},  idx_a,  onehot_idx(e.gnt));
                    chk({e.tag, "_busy"}, busy_a, e.busy);
                end else begin
                    chk({e.tag, "_gnt"},  gnt_b,  e.gnt);
                    chk({e.tag, "_vld"},  vld_b,  |e.gnt);
                    chk({e.tag, "_idx"},  idx_b,  onehot_idx(e.gnt));
                    chk({e.tag, "_busy"}, busy_b, e.busy);
                end
            end
        end
    end

    initial begin
        arst       = 1'b1;
        i_req      = 4'b0000;
        i_req_last = 4'b0000;
        i_ack      = 1'b0;
        @(posedge clk);
        #1;

        // Outputs under reset: combinational lowest-bit grant, never busy
        step("rst_idle", 0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        step("rst_req",  0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b0);
        arst = 1'b0;

        // 1: two requesters alternate
        step("t1_a", 0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b0);
        step("t1_b", 0, 4'b1010, 4'b1111, 1'b1, 4'b1000, 1'b0);
        step("t1_c", 0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b0);
        step("t1_d", 0, 4'b1010, 4'b1111, 1'b1, 4'b1000, 1'b0);

        // 2: full rotation with wrap
        step("t2_0", 0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
        step("t2_1", 0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);
        step("t2_2", 0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
        step("t2_3", 0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
        step("t2_w", 0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);

        // 3: three-beat transaction from requester 0 holds the lock
        reset_pulse();
        step("t3_b1",  0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0);
        step("t3_b2",  0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1);
        step("t3_b3",  0, 4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1);
        step("t3_nxt", 0, 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0);

        // 4: owner 2 drops request; no stealing by requester 0
        step("t4_lock", 0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0);
        step("t4_drp1", 0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1);
        step("t4_drp2", 0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1);
        step("t4_back", 0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1);
        step("t4_last", 0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
        step("t4_wrap", 0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0);

        // 5: no ack keeps grant and pointer (pointer now favours bit 3)
        for (int i = 0; i < 5; i++)
            step("t5_hold", 0, 4'b0110, 4'b1111, 1'b0, 4'b0010, 1'b0);
        step("t5_noreq", 0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0);
        step("t5_ptr",   0, 4'b1110, 4'b1111, 1'b0, 4'b1000, 1'b0);

        // 6: async reset abandons a lock on owner 3
        step("t6_lock", 0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0);
        step("t6_held", 0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1);
        arst = 1'b1;
        #1;
        chk("t6_async_busy", busy_a, 0);
        chk("t6_async_gnt",  gnt_a,  4'b1000);
        arst = 1'b0;
        step("t6_after", 0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b0);

        // Non-locking instance re-arbitrates every accepted beat
        reset_pulse();
        step("nl_0", 1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0);
        step("nl_1", 1, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b0);
        step("nl_2", 1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0);

        i_req = 4'b0000;
        i_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (sb.size() != 0) @(negedge clk);
        end
        chk("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
